// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-80 key schedule and round datapath.
// Holds widths, the 4-bit S-box table and the key-register update function.
package present_pkg;

  localparam int unsigned KEY_W  = 80;
  localparam int unsigned RK_W   = 64;
  localparam int unsigned ROUNDS = 32;
  localparam int unsigned RND_W  = 6;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned ROT_L  = 61;
  localparam int unsigned CNT_LO = 15;

  // Rotating left by ROT_L equals taking the low ROT_R bits to the top.
  localparam int unsigned ROT_R  = KEY_W - ROT_L;

  localparam logic [NIB_W-1:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    KS_HOLD   = 2'd0,
    KS_LOAD   = 2'd1,
    KS_UPDATE = 2'd2
  } ks_op_e;

  function automatic logic [NIB_W-1:0] sbox_lookup(input logic [NIB_W-1:0] x);
    return SBOX[x];
  endfunction

  // Round 0 loads, rounds 1..ROUNDS-1 advance, anything at or above ROUNDS holds.
  function automatic ks_op_e ks_decode(input logic [RND_W-1:0] rnd);
    if (rnd == '0)
      return KS_LOAD;
    else if (rnd < RND_W'(ROUNDS))
      return KS_UPDATE;
    else
      return KS_HOLD;
  endfunction

  function automatic logic [KEY_W-1:0] ks_update(input logic [KEY_W-1:0] k,
                                                 input logic [CNT_W-1:0] c);
    logic [KEY_W-1:0] t;
    t = {k[ROT_R-1:0], k[KEY_W-1:ROT_R]};
    t[KEY_W-1 -: NIB_W] = sbox_lookup(t[KEY_W-1 -: NIB_W]);
    t[CNT_LO +: CNT_W]  = t[CNT_LO +: CNT_W] ^ c;
    return t;
  endfunction

endpackage

// File: rtl/present_sbox4.sv
// PRESENT 4-bit combinational S-box, shared by the key schedule and the round datapath.
module present_sbox4
  import present_pkg::*;
(
  input  logic [NIB_W-1:0] i_nib,
  output logic [NIB_W-1:0] o_nib
);

  assign o_nib = sbox_lookup(i_nib);

endmodule

// File: rtl/present_ksa.sv
// PRESENT-80 key schedule: loads the master key at round 0 and steps the
// 80-bit key register once per round so new_key tracks K_round.
module present_ksa
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  input  logic [RND_W-1:0] round,
  output logic [RK_W-1:0]  new_key
);

  logic [KEY_W-1:0] r_key;
  logic [KEY_W-1:0] w_rot;
  logic [KEY_W-1:0] w_next;
  logic [NIB_W-1:0] w_sbox_out;
  ks_op_e           w_op;

  assign w_rot = {r_key[ROT_R-1:0], r_key[KEY_W-1:ROT_R]};

  present_sbox4 u_sbox (
    .i_nib (w_rot[KEY_W-1 -: NIB_W]),
    .o_nib (w_sbox_out)
  );

  // Substituted top nibble and round-counter injection on the rotated key.
  always_comb begin
    w_next                     = w_rot;
    w_next[KEY_W-1 -: NIB_W]   = w_sbox_out;
    w_next[CNT_LO +: CNT_W]    = w_rot[CNT_LO +: CNT_W] ^ round[CNT_W-1:0];
  end

  assign w_op = ks_decode(round);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_key <= '0;
    end else begin
      case (w_op)
        KS_LOAD:   r_key <= key;
        KS_UPDATE: r_key <= w_next;
        default:   r_key <= r_key;
      endcase
    end
  end

  assign new_key = r_key[KEY_W-1 -: RK_W];

endmodule

// File: tb/tb_present_ksa.sv
// Directed bench for present_ksa: hand-computed round keys plus an
// independent reference of the key-register update for full schedules.
module tb_present_ksa;

  logic        clk;
  logic        rst;
  logic [79:0] key;
  logic [5:0]  round;
  logic [63:0] new_key;

  int unsigned n_vec;
  int unsigned n_err;
  logic [79:0] m_key;

  present_ksa dut (
    .clk     (clk),
    .rst     (rst),
    .key     (key),
    .round   (round),
    .new_key (new_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  // Reference step: bitwise rotate-left by 61, S-box on top nibble, XOR counter.
  function automatic logic [79:0] ref_step(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] t;
    for (int i = 0; i < 80; i++) t[(i + 61) % 80] = k[i];
    t[79:76] = ref_sbox(t[79:76]);
    for (int j = 0; j < 5; j++) t[15 + j] = t[15 + j] ^ c[j];
    return t;
  endfunction

  // Load k at round 0, then step rounds 1..last checking each key against the model.
  task automatic run_key(input logic [79:0] k, input int last, input string tag);
    @(negedge clk);
    round = 6'd0;
    key   = k;
    m_key = k;
    for (int r = 1; r <= last; r++) begin
      @(negedge clk);
      round = 6'(r);
      key   = ~k;
      #1;
      check_vec($sformatf("%s_r%0d", tag, r), new_key, m_key[79:16]);
      if (r < 32) m_key = ref_step(m_key, 5'(r));
    end
  endtask

  initial begin
    logic [79:0] keys [5];
    logic [63:0] k32;
    n_vec = 0;
    n_err = 0;
    keys[0] = 80'h0123_4567_89AB_CDEF_0123;
    keys[1] = 80'hDEAD_BEEF_CAFE_BABE_1234;
    keys[2] = 80'h8000_0000_0000_0000_0001;
    keys[3] = 80'hA5A5_5A5A_F0F0_0F0F_3C3C;
    keys[4] = 80'h1357_9BDF_2468_ACE0_FFFF;

    // Reset with all-ones key presented: register must stay cleared.
    rst   = 1'b0;
    key   = '1;
    round = 6'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_vec($sformatf("reset_c%0d", i), new_key, 64'h0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Zero key: hand-computed early round keys.
    @(negedge clk);
    round = 6'd0;
    key   = '0;
    @(negedge clk); round = 6'd1; #1 check_vec("zero_k1", new_key, 64'h0000000000000000);
    @(negedge clk); round = 6'd2; #1 check_vec("zero_k2", new_key, 64'hC000000000000000);
    @(negedge clk); round = 6'd3; #1 check_vec("zero_k3", new_key, 64'h5000180000000001);
    run_key(80'h0, 32, "zero");

    // All-ones key: K1 by hand, rest against the model.
    @(negedge clk);
    round = 6'd0;
    key   = '1;
    @(negedge clk); round = 6'd1; #1 check_vec("ones_k1", new_key, 64'hFFFFFFFFFFFFFFFF);
    run_key('1, 32, "ones");

    // Hold beyond round 32.
    k32 = m_key[79:16];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); round = 6'd33; #1 check_vec($sformatf("hold33_c%0d", i), new_key, k32);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); round = 6'd63; #1 check_vec($sformatf("hold63_c%0d", i), new_key, k32);
    end

    // Back-to-back schedules with the counter wrapping 32 -> 0.
    for (int n = 0; n < 5; n++) run_key(keys[n], 32, $sformatf("b2b%0d", n));

    // Mid-run reset at round 10, then a fresh load.
    run_key(keys[1], 10, "mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_vec("mid_reset", new_key, 64'h0);
    rst   = 1'b1;
    round = 6'd0;
    key   = keys[3];
    @(negedge clk);
    round = 6'd1;
    #1 check_vec("mid_reload_k1", new_key, keys[3][79:16]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
